// File: rtl/fwd_pkg.sv
// fwd_pkg: select codes, stage record and producer helper shared by the forwarding controller.
package fwd_pkg;
  localparam int FWD_REG_AW = 5;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_t;
  function automatic logic produces(stage_t s, logic [FWD_REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
  endfunction
  function automatic logic [1:0] fwd_sel(stage_t ex, stage_t mem, logic [FWD_REG_AW-1:0] r);
    return produces(ex, r) ? FWD_MEM : produces(mem, r) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/fwd_stage_reg.sv
// fwd_stage_reg: stage-record register, cleared by reset or loaded with a bubble on request.
module fwd_stage_reg import fwd_pkg::*; (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) q_o <= '0;
    else q_o <= bubble_i ? '0 : d_i;
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX-operand forwarding select and load-use stall controller.
// Optional stall-cycle counter port enabled by FWD_STALL_CNT_EN.
module fwd_ctrl import fwd_pkg::*; #(
  parameter int REG_AW = FWD_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        ex_fwdA_o,
  output logic [1:0]        ex_fwdB_o,
  output logic              stall_o
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);
  stage_t ex_q, mem_q, wb_q, ex_d;
  logic hazard, bubble;
  assign ex_d   = '{valid: 1'b1, rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};
  assign hazard = id_valid_i && ex_q.memread && (produces(ex_q, id_rs_i) || produces(ex_q, id_rt_i));
  assign stall_o = hazard && !flush_i;
  assign bubble  = flush_i || stall_o || !id_valid_i;
  fwd_stage_reg u_ex  (.clk_i(clk_i), .rst_i(rst_i), .bubble_i(bubble), .d_i(ex_d),  .q_o(ex_q));
  fwd_stage_reg u_mem (.clk_i(clk_i), .rst_i(rst_i), .bubble_i(1'b0),   .d_i(ex_q),  .q_o(mem_q));
  fwd_stage_reg u_wb  (.clk_i(clk_i), .rst_i(rst_i), .bubble_i(1'b0),   .d_i(mem_q), .q_o(wb_q));
  // WB is tracked for pipeline visibility only; the register file write-through covers it
  logic unused_wb;
  assign unused_wb = ^wb_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      ex_fwdA_o <= FWD_RF;
      ex_fwdB_o <= FWD_RF;
    end else begin
      ex_fwdA_o <= bubble ? FWD_RF : fwd_sel(ex_q, mem_q, id_rs_i);
      ex_fwdB_o <= bubble ? FWD_RF : fwd_sel(ex_q, mem_q, id_rt_i);
    end
`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stall_cnt_o <= '0;
    else if (stall_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule
